// File: rtl/service_arbiter_pkg.sv
// Shared encodings for the service arbiter: FSM states, service one-hot
// patterns (bit3 = service 1 .. bit0 = service 4) and display-select codes.
package service_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_S1    = 3'd1,
    ST_S2    = 3'd2,
    ST_S3    = 3'd3,
    ST_S4    = 3'd4,
    ST_DONE  = 3'd5,
    ST_ALARM = 3'd6
  } state_t;

  localparam logic [3:0] SVC1     = 4'b1000;
  localparam logic [3:0] SVC2     = 4'b0100;
  localparam logic [3:0] SVC3     = 4'b0010;
  localparam logic [3:0] SVC4     = 4'b0001;
  localparam logic [3:0] SVC_NONE = 4'b0000;
  localparam logic [3:0] LED_ALL  = 4'b1111;

  localparam logic [2:0] DISP_TIME  = 3'd0;
  localparam logic [2:0] DISP_SVC1  = 3'd1;
  localparam logic [2:0] DISP_SVC2  = 3'd2;
  localparam logic [2:0] DISP_SVC3  = 3'd3;
  localparam logic [2:0] DISP_SVC4  = 3'd4;
  localparam logic [2:0] DISP_ALARM = 3'd5;

  // Service state selected by a one-hot switch pattern (IDLE if not one-hot)
  function automatic state_t state_for(input logic [3:0] pattern);
    case (pattern)
      SVC1:    return ST_S1;
      SVC2:    return ST_S2;
      SVC3:    return ST_S3;
      SVC4:    return ST_S4;
      default: return ST_IDLE;
    endcase
  endfunction

  // One-hot service owned by a service state, NONE for every other state
  function automatic logic [3:0] svc_onehot(input state_t st);
    case (st)
      ST_S1:   return SVC1;
      ST_S2:   return SVC2;
      ST_S3:   return SVC3;
      ST_S4:   return SVC4;
      default: return SVC_NONE;
    endcase
  endfunction

  // Display source shown while in a given state
  function automatic logic [2:0] svc_disp(input state_t st);
    case (st)
      ST_S1:    return DISP_SVC1;
      ST_S2:    return DISP_SVC2;
      ST_S3:    return DISP_SVC3;
      ST_S4:    return DISP_SVC4;
      ST_ALARM: return DISP_ALARM;
      default:  return DISP_TIME;
    endcase
  endfunction

endpackage

// File: rtl/service_arbiter_input_sync_edge.sv
// Synchronizer chain for asynchronous board inputs, plus a run-length counter
// that flags when the synchronized pattern has held steady, and a registered
// rising-edge pulse per bit.
module input_sync_edge #(
  parameter int WIDTH         = 4,
  parameter int STAGES        = 2,
  parameter int STABLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] sample,
  output logic             stable,
  output logic [WIDTH-1:0] rise
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] chain [STAGES];
  logic [WIDTH-1:0] prev;
  logic [CW-1:0]    run_cnt;

  // Shift through the synchronizer, remember the previous synchronized value
  // and count how many consecutive samples have matched it (saturating).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
      prev    <= '0;
      run_cnt <= '0;
      rise    <= '0;
    end else begin
      chain[0] <= raw;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      prev <= chain[STAGES-1];
      rise <= chain[STAGES-1] & ~prev;
      if (chain[STAGES-1] != prev) run_cnt <= '0;
      else if (run_cnt != CNT_MAX) run_cnt <= run_cnt + 1'b1;
    end
  end

  assign sample = prev;
  assign stable = (run_cnt == CNT_MAX);

endmodule

// File: rtl/service_arbiter.sv
// Central sequencer: decides which service owns display, buttons and LEDs,
// handles alarm preemption/deferral and routes button pulses to the owner.
module service_arbiter
  import service_arbiter_pkg::*;
#(
  parameter int STABLE_CYCLES = 2,
  parameter int ALARM_TIMEOUT = 60,
  parameter int TW            = 6
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] spdt_service,
  input  logic [4:0] push,
  input  logic [3:0] finish,
  input  logic       alarm_hit,
  output logic [3:0] grant,
  output logic [2:0] disp_sel,
  output logic [4:0] svc_push,
  output logic [3:0] svc_led,
  output logic       alarm_active,
  output logic       alarm_pending,
  output logic       err
);

  localparam logic [TW-1:0] TO_LAST = TW'(ALARM_TIMEOUT - 1);

  state_t      state;
  state_t      next_state;
  logic        next_pending;
  logic        next_err;
  logic [3:0]  sw_val;
  logic        sw_stable;
  logic [3:0]  sw_rise_unused;
  logic [4:0]  push_rise;
  logic [4:0]  push_sample_unused;
  logic        push_stable_unused;
  logic [TW-1:0] to_cnt;
  logic        timeout;
  logic        sw_zero;
  logic        sw_single;
  logic [3:0]  cur_svc;

  input_sync_edge #(.WIDTH(4), .STAGES(2), .STABLE_CYCLES(STABLE_CYCLES)) u_sw_sync (
    .clk    (clk),
    .resetn (resetn),
    .raw    (spdt_service),
    .sample (sw_val),
    .stable (sw_stable),
    .rise   (sw_rise_unused)
  );

  input_sync_edge #(.WIDTH(5), .STAGES(2), .STABLE_CYCLES(1)) u_push_sync (
    .clk    (clk),
    .resetn (resetn),
    .raw    (push),
    .sample (push_sample_unused),
    .stable (push_stable_unused),
    .rise   (push_rise)
  );

  assign sw_zero   = (sw_val == SVC_NONE);
  assign sw_single = $onehot(sw_val);
  assign cur_svc   = svc_onehot(state);
  assign timeout   = (ALARM_TIMEOUT != 0) && (to_cnt == TO_LAST);

  // Next-state rules: alarm beats finish, finish beats a switch change,
  // and alarms raised during time/alarm setting are deferred.
  always_comb begin
    next_state   = state;
    next_pending = alarm_pending;
    next_err     = err;
    if (sw_stable) next_err = !sw_zero && !sw_single;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (alarm_hit || alarm_pending) begin
          next_state   = ST_ALARM;
          next_pending = 1'b0;
        end else if (state == ST_IDLE) begin
          if (sw_stable && sw_single) next_state = state_for(sw_val);
        end else if (sw_stable && sw_zero) begin
          next_state = ST_IDLE;
        end
      end
      ST_S1, ST_S2, ST_S3, ST_S4: begin
        if (alarm_hit && state == ST_S3) begin
          next_state = ST_ALARM;
        end else begin
          if (alarm_hit && (state == ST_S1 || state == ST_S2)) next_pending = 1'b1;
          if ((finish & cur_svc) != SVC_NONE) next_state = ST_DONE;
          else if (sw_stable && sw_val != cur_svc) next_state = ST_IDLE;
        end
      end
      ST_ALARM: begin
        if (finish[0] || timeout) next_state = (sw_stable && sw_zero) ? ST_IDLE : ST_DONE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // State register with every visible output registered from the next state;
  // the alarm timeout counter restarts whenever ALARM is (re)entered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      grant         <= SVC_NONE;
      disp_sel      <= DISP_TIME;
      svc_led       <= SVC_NONE;
      alarm_active  <= 1'b0;
      alarm_pending <= 1'b0;
      err           <= 1'b0;
      to_cnt        <= '0;
    end else begin
      state         <= next_state;
      alarm_pending <= next_pending;
      err           <= next_err;
      disp_sel      <= svc_disp(next_state);
      alarm_active  <= (next_state == ST_ALARM);
      grant         <= (next_state == ST_ALARM) ? SVC4 : svc_onehot(next_state);
      svc_led       <= (next_state == ST_ALARM) ? LED_ALL : svc_onehot(next_state);
      to_cnt        <= (state == ST_ALARM && next_state == ST_ALARM) ? to_cnt + 1'b1 : '0;
    end
  end

  assign svc_push = push_rise & {5{grant != SVC_NONE}};

endmodule

// File: tb/tb_service_arbiter.sv
// Self-checking bench for service_arbiter: a sample-history model predicts
// every output each cycle, and directed scenarios pin key values literally.
module tb_service_arbiter;

  localparam int STABLE  = 2;
  localparam int TIMEOUT = 60;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] spdt_service = '0;
  logic [4:0] push = '0;
  logic [3:0] finish = '0;
  logic       alarm_hit = 1'b0;
  logic [3:0] grant;
  logic [2:0] disp_sel;
  logic [4:0] svc_push;
  logic [3:0] svc_led;
  logic       alarm_active;
  logic       alarm_pending;
  logic       err;

  int assertions = 0;
  int failures = 0;

  // Model state: 0 idle, 1..4 service n, 5 done, 6 alarm
  int         m_state;
  bit         m_pending;
  bit         m_err;
  int         m_age;
  logic [4:0] m_rise;
  logic [3:0] sw_q[$];
  logic [4:0] pb_q[$];

  logic [18:0] dut_vec;
  assign dut_vec = {grant, disp_sel, svc_push, svc_led, alarm_active, alarm_pending, err};

  service_arbiter #(.STABLE_CYCLES(STABLE), .ALARM_TIMEOUT(TIMEOUT), .TW(6)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .spdt_service  (spdt_service),
    .push          (push),
    .finish        (finish),
    .alarm_hit     (alarm_hit),
    .grant         (grant),
    .disp_sel      (disp_sel),
    .svc_push      (svc_push),
    .svc_led       (svc_led),
    .alarm_active  (alarm_active),
    .alarm_pending (alarm_pending),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  function automatic logic [3:0] svc_mask(input int n);
    logic [3:0] top = 4'b1000;
    return top >> (n - 1);
  endfunction

  function automatic int svc_number(input logic [3:0] pat);
    for (int k = 1; k <= 4; k++) if (pat == svc_mask(k)) return k;
    return 0;
  endfunction

  function automatic logic [18:0] expected_vec();
    logic [3:0] g;
    logic [2:0] d;
    logic [3:0] l;
    g = '0; d = '0; l = '0;
    if (m_state >= 1 && m_state <= 4) begin
      g = svc_mask(m_state); d = 3'(m_state); l = svc_mask(m_state);
    end else if (m_state == 6) begin
      g = 4'b0001; d = 3'd5; l = 4'b1111;
    end
    return {g, d, (g != 0) ? m_rise : 5'b0, l, m_state == 6, m_pending, m_err};
  endfunction

  task automatic model_reset();
    m_state = 0; m_pending = 0; m_err = 0; m_age = 0; m_rise = '0;
    sw_q = {4'b0, 4'b0, 4'b0};
    pb_q = {5'b0, 5'b0, 5'b0};
  endtask

  // One clock edge of the behavioural model, from the inputs seen at that edge
  task automatic model_step();
    int n;
    int svc;
    logic [3:0] pat;
    bit steady;
    n = sw_q.size();
    pat = sw_q[n-3];
    steady = 1;
    for (int j = 0; j < STABLE; j++)
      if (n - 3 - j < 0 || sw_q[n-3-j] != pat) steady = 0;
    m_rise = pb_q[n-2] & ~pb_q[n-3];
    sw_q.push_back(spdt_service);
    pb_q.push_back(push);
    if (steady) m_err = ($countones(pat) > 1);
    svc = svc_number(pat);
    if (m_state == 0 || m_state == 5) begin
      if (alarm_hit || m_pending) begin
        m_state = 6; m_pending = 0; m_age = 1;
      end else if (m_state == 0) begin
        if (steady && svc != 0) m_state = svc;
      end else if (steady && pat == 0) begin
        m_state = 0;
      end
    end else if (m_state >= 1 && m_state <= 4) begin
      if (alarm_hit && m_state == 3) begin
        m_state = 6; m_age = 1;
      end else begin
        if (alarm_hit && m_state <= 2) m_pending = 1;
        if (finish[4-m_state]) m_state = 5;
        else if (steady && pat != svc_mask(m_state)) m_state = 0;
      end
    end else begin
      if (finish[0] || (TIMEOUT != 0 && m_age == TIMEOUT)) m_state = (steady && pat == 0) ? 0 : 5;
      else m_age++;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      checkOutput("model_compare", {13'b0, dut_vec}, {13'b0, expected_vec()});
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic [3:0] sw, input logic [4:0] pb, input logic [3:0] fin,
                               input logic ah, input int cycles);
    spdt_service = sw; push = pb; finish = fin; alarm_hit = ah;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    checkOutput("reset_outputs", {13'b0, dut_vec}, 32'h0);
    resetn = 1'b1;

    // Select service 1, route a single up-button pulse, hold the middle button
    applyStimulus(4'b1000, 5'b0, 4'b0, 1'b0, 5);
    checkOutput("s1_grant", grant, 4'b1000);
    checkOutput("s1_disp", disp_sel, 3'd1);
    checkOutput("s1_led", svc_led, 4'b1000);
    applyStimulus(4'b1000, 5'b00001, 4'b0, 1'b0, 1);
    applyStimulus(4'b1000, 5'b0, 4'b0, 1'b0, 1);
    checkOutput("push_before", svc_push, 5'b0);
    applyStimulus(4'b1000, 5'b0, 4'b0, 1'b0, 1);
    checkOutput("push_pulse", svc_push, 5'b00001);
    applyStimulus(4'b1000, 5'b0, 4'b0, 1'b0, 1);
    checkOutput("push_after", svc_push, 5'b0);
    applyStimulus(4'b1000, 5'b10000, 4'b0, 1'b0, 6);
    applyStimulus(4'b1000, 5'b0, 4'b0, 1'b0, 3);

    // Finish service 1, stay DONE while switch is up, then return via 0000
    applyStimulus(4'b1000, 5'b0, 4'b1000, 1'b0, 1);
    checkOutput("done_grant", grant, 4'b0);
    checkOutput("done_led", svc_led, 4'b0);
    applyStimulus(4'b1000, 5'b0, 4'b0, 1'b0, 6);
    checkOutput("done_held", grant, 4'b0);
    applyStimulus(4'b0000, 5'b0, 4'b0, 1'b0, 5);
    applyStimulus(4'b0010, 5'b0, 4'b0, 1'b0, 5);
    checkOutput("s3_grant", grant, 4'b0010);
    checkOutput("s3_disp", disp_sel, 3'd3);

    // Alarm and finish together in S3: alarm wins
    applyStimulus(4'b0010, 5'b0, 4'b0010, 1'b1, 1);
    checkOutput("alarm_vec", {13'b0, dut_vec}, {13'b0, 4'b0001, 3'd5, 5'b0, 4'b1111, 1'b1, 1'b0, 1'b0});
    applyStimulus(4'b0010, 5'b00010, 4'b0, 1'b0, 1);
    applyStimulus(4'b0010, 5'b0, 4'b0, 1'b0, 3);
    applyStimulus(4'b0010, 5'b0, 4'b0001, 1'b0, 1);
    checkOutput("alarm_exit_done", {alarm_active, grant}, 5'b0);
    applyStimulus(4'b0000, 5'b0, 4'b0, 1'b0, 5);

    // Deferred alarm while in S2
    applyStimulus(4'b0100, 5'b0, 4'b0, 1'b0, 5);
    checkOutput("s2_grant", grant, 4'b0100);
    applyStimulus(4'b0100, 5'b0, 4'b0, 1'b1, 1);
    checkOutput("pending_set", {alarm_pending, grant}, {1'b1, 4'b0100});
    applyStimulus(4'b0100, 5'b0, 4'b0, 1'b0, 2);
    applyStimulus(4'b0100, 5'b0, 4'b0, 1'b1, 1);
    applyStimulus(4'b0000, 5'b0, 4'b0, 1'b0, 5);
    checkOutput("pending_idle", {alarm_active, alarm_pending, grant}, {1'b0, 1'b1, 4'b0});
    applyStimulus(4'b0000, 5'b0, 4'b0, 1'b0, 1);
    checkOutput("pending_alarm", {alarm_active, alarm_pending, disp_sel}, {1'b1, 1'b0, 3'd5});
    applyStimulus(4'b0000, 5'b0, 4'b0001, 1'b0, 1);
    checkOutput("pending_exit", alarm_active, 1'b0);

    // Alarm runs to its timeout
    applyStimulus(4'b0000, 5'b0, 4'b0, 1'b1, 1);
    n = 0;
    while (alarm_active && n < 200) begin
      n++;
      applyStimulus(4'b0000, 5'b0, 4'b0, 1'b0, 1);
    end
    checkOutput("timeout_cycles", n, TIMEOUT);
    applyStimulus(4'b0001, 5'b0, 4'b0, 1'b0, 5);
    checkOutput("s4_disp", disp_sel, 3'd4);
    applyStimulus(4'b0001, 5'b0, 4'b0, 1'b1, 1);
    checkOutput("s4_alarm_ignored", {alarm_active, disp_sel}, {1'b0, 3'd4});
    applyStimulus(4'b0000, 5'b0, 4'b0, 1'b0, 5);

    // Invalid pattern, recovery, then asynchronous reset mid-S2
    applyStimulus(4'b1100, 5'b0, 4'b0, 1'b0, 5);
    checkOutput("err_set", {err, grant}, {1'b1, 4'b0});
    applyStimulus(4'b1100, 5'b11111, 4'b0, 1'b0, 1);
    applyStimulus(4'b1100, 5'b0, 4'b0, 1'b0, 2);
    checkOutput("err_push_blocked", svc_push, 5'b0);
    applyStimulus(4'b1100, 5'b0, 4'b0, 1'b0, 1);
    applyStimulus(4'b0100, 5'b0, 4'b0, 1'b0, 5);
    checkOutput("err_clear", {err, grant}, {1'b0, 4'b0100});
    applyStimulus(4'b0100, 5'b0, 4'b0, 1'b0, 1);
    #2 resetn = 1'b0;
    #1 checkOutput("async_reset", {13'b0, dut_vec}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus(4'b0000, 5'b0, 4'b0, 1'b0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/service_arbiter.md
Name: service_arbiter

Overview:
Central sequencer deciding which service (1 time-set, 2 alarm-set, 3 stopwatch, 4 alarm/mini-game) owns the 4-digit display, push buttons and service LEDs. Decodes the 4 service switches into a validated one-hot grant. Preempts with the alarm, tracks finish handshakes, and routes synchronized single-cycle push pulses only to the granted service. Sits between the raw board inputs and the four service blocks, feeding the top-level display mux.

Parameters:
STABLE_CYCLES, 2, consecutive cycles a switch pattern must hold before it is acted on (min 1)
ALARM_TIMEOUT, 60, clk cycles in ALARM before auto-dismiss (1 Hz clk => 60 s); 0 disables
TW, 6, width of timeout counter (must hold ALARM_TIMEOUT)

Ports:
clk  in  1  system tick clock
resetn  in  1  asynchronous active-low reset
spdt_service  in  4  service switches, bit3=service1 .. bit0=service4, asynchronous to clk
push  in  5  raw buttons {m,r,l,d,u}, asynchronous
finish  in  4  per-service done pulses, bit3=service1 .. bit0=service4, 1 cycle
alarm_hit  in  1  1-cycle pulse when current time equals alarm time
grant  out  4  one-hot owner, same bit order as spdt_service; 0 = none
disp_sel  out  3  0 current time, 1..4 service n, 5 alarm flash
svc_push  out  5  synchronized rising-edge pulses, zero unless grant!=0
svc_led  out  4  service indicator LEDs
alarm_active  out  1  high in ALARM
alarm_pending  out  1  deferred alarm waiting
err  out  1  invalid (multi-bit) switch pattern held

Behaviour:
- Reset (resetn=0, async): state IDLE, all outputs 0, sync flops 0, counters 0.
- spdt_service and push pass through 2-flop synchronizers. A pattern is "stable" after STABLE_CYCLES identical synchronized samples.
- States: IDLE, S1, S2, S3, S4, DONE, ALARM.
- IDLE: grant=0, disp_sel=0. A stable single-bit pattern for service n moves to Sn on the next edge. A stable 0000 stays. A stable multi-bit pattern stays, with err=1. err clears when a single-bit or 0000 pattern becomes stable.
- Sn: grant=one-hot n, disp_sel=n, svc_led=one-hot n.
  - finish[n] -> DONE.
  - Stable pattern != n -> IDLE. No finish is implied.
  - finish bits of other services are ignored.
- DONE: grant=0, svc_led=0, disp_sel=0. Stays until a stable 0000 is seen, then IDLE. This prevents immediate re-entry while the switch is still up.
- alarm_hit handling:
  - IDLE, DONE or S3 -> ALARM. Stopwatch is preempted and its grant is dropped.
  - S1 or S2 -> set alarm_pending; current state continues. On the first cycle in IDLE or DONE with pending=1, go to ALARM and clear pending.
  - S4 or ALARM -> ignored.
  - A second alarm_hit while pending has no further effect.
- ALARM: grant=0001 (service 4 runs the mini-game), disp_sel=5, alarm_active=1, svc_led=1111.
  - Exits on finish[0] or on timeout counter == ALARM_TIMEOUT-1.
  - Exit target: DONE if the stable pattern is nonzero, else IDLE.
  - Timeout counter clears on entry.
- Simultaneous events in one cycle: alarm_hit beats finish (in S3, go to ALARM, not DONE). finish beats a switch change (Sn with finish[n] goes to DONE).
- Push routing: edge = sync & ~prev. svc_push = edge when grant!=0, else 0. Latency is 3 clk edges from first sampled high to pulse. Pulse width is exactly 1 cycle. A held button gives one pulse. Pulses are gated combinationally with the registered grant, so no pulse leaks in the cycle grant drops.
- All outputs are registered except svc_push gating.
- Asserting resetn mid-ALARM or mid-Sn returns to IDLE immediately. A pending alarm is lost.

Decomposition:
- Shared package: state encoding constants (IDLE..ALARM), service one-hot constants (SVC1=1000 .. SVC4=0001, NONE=0000), disp_sel codes.
- Sub-module input_sync_edge (parameterized width and stages; synchronizer + stability counter + rising-edge detect), instantiated for switches and buttons.

Test Plan:
1. Reset, spdt=1000 for 3 cycles -> grant=1000, disp_sel=1, svc_led=1000. push_u pulse -> svc_push=00001 for 1 cycle, 3 edges later.
2. In S1, finish=1000 -> DONE, grant=0, svc_led=0. spdt held 1000 stays DONE. spdt=0000 stable -> IDLE.
3. In S3, alarm_hit and finish=0010 in same cycle -> ALARM, grant=0001, disp_sel=5. finish=0001 with spdt=0010 -> DONE.
4. In S2, alarm_hit -> alarm_pending=1, grant stays 0100. spdt=0000 stable -> IDLE, then ALARM next edge, pending=0.
5. IDLE, alarm_hit, no finish -> alarm_active drops after exactly ALARM_TIMEOUT cycles, state IDLE.
6. spdt=1100 stable -> err=1, grant=0, all push pulses suppressed. spdt=0100 -> err=0, grant=0100. Assert resetn=0 mid-S2 -> all outputs 0 asynchronously.
